exe_stage: RTL
==============

# exe_stage

Execute stage of the 5-stage MIPS pipeline plus its EXE/MEM boundary register. Consumes the ID/EXE register outputs, resolves operand forwarding from the MEM and WB stages, and computes single-cycle ALU results. It runs an optional iterative multiply/divide unit that stalls the upstream pipeline. Registered results feed the MEM stage.

## Interface
Parameters:
- none; widths come from the shared package (`REG_FILE_ADDR_LEN`=5, `EXE_CMD_LEN`=4).

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  reset, synchronous, active-low.
- EXE_CMD  in  4  operation code from ID/EXE.
- val1, val2  in  32  operands from ID/EXE; val2 is immediate when is_imm=1.
- ST_value  in  32  store data (reg2) from ID/EXE.
- is_imm  in  1  val2 holds an immediate; val2 never forwarded.
- src1, src2  in  5  source register numbers.
- dest  in  5  destination register.
- MEM_R_EN, MEM_W_EN, WB_EN  in  1  control from ID/EXE.
- wb_dest  in  5  WB-stage destination.
- wb_en  in  1  WB-stage write enable.
- wb_value  in  32  WB-stage write data.
- alu_result_out  out  32  registered result.
- st_value_out  out  32  registered, forwarded store data.
- dest_out  out  5  registered destination.
- MEM_R_EN_out, MEM_W_EN_out, WB_EN_out  out  1  registered control.
- stall  out  1  combinational; freezes PC, IF/ID and ID/EXE while high.

## Operation
- Commands: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT (signed), A MUL (low 32 bits), B DIVU, C REMU. D–F are reserved and give result 0.
- Shift amount is op2[4:0]. Arithmetic wraps modulo 2^32, with no overflow flag.
- Forwarding applies to op1 (src1), op2 (src2, only when is_imm=0) and store data (src2). Priority, for a source s≠0:
  - MEM: own registered output, used if WB_EN_out=1, MEM_R_EN_out=0 and dest_out==s.
  - WB: used if wb_en=1 and wb_dest==s.
  - Otherwise the ID/EXE value.
- Register 0 is never forwarded.
- Load-use hazards are not handled here; the hazard unit owns them.
- Muldiv FSM:
  - IDLE → BUSY when EXE_CMD∈{A,B,C}. Forwarded operands are latched at that edge and count=0.
  - BUSY: one iteration per cycle. After the count=31 iteration it goes to DONE.
  - DONE → IDLE unconditionally.
  - MUL uses shift-add; DIVU/REMU use a restoring divider.
  - Divide by zero gives quotient 0xFFFFFFFF and remainder equal to the dividend.
- stall = (IDLE and muldiv cmd) or BUSY.
- Bubble rule: while stall=1, the output register loads WB_EN_out=MEM_R_EN_out=MEM_W_EN_out=0 and dest_out=0. Data outputs are don't-care.
- In DONE the output register captures the muldiv result with the held ID/EXE control and dest.

## Timing
- ALU ops: operands in cycle N, outputs valid after posedge ending N (1-cycle latency).
- Muldiv stall sequence:
  - Cycle 0: IDLE, stall=1.
  - Cycles 1–32: BUSY, stall=1.
  - Cycle 33: DONE, stall=0.
  - Result is visible at the outputs in cycle 34. stall is high for exactly 33 cycles.
- A muldiv cmd arriving in the cycle after DONE starts a new sequence; there is no dead cycle.
- Reset (rst=0 at posedge):
  - All outputs register to 0, and FSM goes to IDLE, count=0.
  - Reset wins over BUSY/DONE mid-operation; the partial result is discarded.
  - stall is 0 while the FSM is in reset IDLE unless a muldiv cmd is present.
- Forwarding is combinational in cycle 0 only; later changes on wb_* do not affect a latched muldiv.

## Configuration
- `EXE_MULDIV_EN` defined: the muldiv FSM and sub-module are present, and behaviour is as above.
- `EXE_MULDIV_EN` undefined: codes A–C behave as reserved (1-cycle, result 0), stall is tied 0, and no muldiv state exists.

## Structure
- Shared package `exe_pkg` holds:
  - `REG_FILE_ADDR_LEN` and `EXE_CMD_LEN`.
  - EXE_CMD code constants, also imported by the ID stage.
  - FSM state typedef (IDLE/BUSY/DONE).
- One sub-module: `muldiv_iter`, which holds the operand latches, 5-bit counter, shift-add/restoring datapath and done pulse. It is instantiated only under `EXE_MULDIV_EN`.

## Test plan
- ADD val1=7, val2=5, WB_EN=1, dest=3 → next cycle alu_result_out=12, dest_out=3, WB_EN_out=1.
- Back-to-back ADD r3=1+2 then SUB src1=3, val1=stale 0, val2=1 → MEM forward, result 2. Repeat with wb_dest=3, wb_value=9 also present → MEM still wins, result 2.
- MUL 0xFFFFFFFF×3 → stall high 33 cycles with bubble outputs, then alu_result_out=0xFFFFFFFD.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
- rst=0 at BUSY cycle 10 → all outputs 0 next cycle, stall falls, and the next ADD completes normally.
- Without `EXE_MULDIV_EN`, cmd A → stall never asserts and result is 0 after 1 cycle.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared execute-stage definitions: widths, EXE_CMD codes, muldiv FSM states.
// The EXE_CMD constants are also used by the ID-stage decoder.
package exe_pkg;

    localparam int REG_FILE_ADDR_LEN = 5;
    localparam int EXE_CMD_LEN       = 4;

    localparam logic [EXE_CMD_LEN-1:0] EXE_ADD  = 4'h0;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SUB  = 4'h1;
    localparam logic [EXE_CMD_LEN-1:0] EXE_AND  = 4'h2;
    localparam logic [EXE_CMD_LEN-1:0] EXE_OR   = 4'h3;
    localparam logic [EXE_CMD_LEN-1:0] EXE_NOR  = 4'h4;
    localparam logic [EXE_CMD_LEN-1:0] EXE_XOR  = 4'h5;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SLL  = 4'h6;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SRL  = 4'h7;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SRA  = 4'h8;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SLT  = 4'h9;
    localparam logic [EXE_CMD_LEN-1:0] EXE_MUL  = 4'hA;
    localparam logic [EXE_CMD_LEN-1:0] EXE_DIVU = 4'hB;
    localparam logic [EXE_CMD_LEN-1:0] EXE_REMU = 4'hC;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_e;

    function automatic logic is_muldiv(input logic [EXE_CMD_LEN-1:0] c);
        return (c == EXE_MUL) || (c == EXE_DIVU) || (c == EXE_REMU);
    endfunction

endpackage

// File: rtl/exe_stage_muldiv_iter.sv
// Iterative 32-step multiply (shift-add) / unsigned divide (restoring).
// Module muldiv_iter; instantiated by exe_stage only under EXE_MULDIV_EN.
module muldiv_iter
    import exe_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic                   i_step,
    input  logic [EXE_CMD_LEN-1:0] i_op,
    input  logic [31:0]            i_a,
    input  logic [31:0]            i_b,
    output logic [31:0]            o_result,
    output logic                   o_last
);

    logic [EXE_CMD_LEN-1:0] r_op;
    logic [4:0]             r_count;
    logic [31:0]            r_x;
    logic [31:0]            r_y;
    logic [31:0]            r_acc;

    logic [32:0]            w_sh;
    logic                   w_ge;
    logic [31:0]            w_sub;

    // Divider: shift next dividend bit into the partial remainder.
    assign w_sh  = {r_acc, r_x[31]};
    assign w_ge  = w_sh >= {1'b0, r_y};
    assign w_sub = w_sh[31:0] - r_y;

    assign o_last   = i_step && (r_count == 5'd31);
    assign o_result = (r_op == EXE_DIVU) ? r_x : r_acc;

    // Latch operands on start, then run one shift-add or restoring step per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op    <= '0;
            r_count <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_acc   <= '0;
        end else if (i_start) begin
            r_op    <= i_op;
            r_count <= '0;
            r_x     <= i_a;
            r_y     <= i_b;
            r_acc   <= '0;
        end else if (i_step) begin
            r_count <= r_count + 5'd1;
            if (r_op == EXE_MUL) begin
                if (r_y[0]) begin
                    r_acc <= r_acc + r_x;
                end
                r_x <= {r_x[30:0], 1'b0};
                r_y <= {1'b0, r_y[31:1]};
            end else begin
                r_acc <= w_ge ? w_sub : w_sh[31:0];
                r_x   <= {r_x[30:0], w_ge};
            end
        end
    end

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage with MEM/WB forwarding and the EXE/MEM register.
// Optional iterative muldiv unit enabled by defining EXE_MULDIV_EN.
module exe_stage
    import exe_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [EXE_CMD_LEN-1:0]       EXE_CMD,
    input  logic [31:0]                  val1,
    input  logic [31:0]                  val2,
    input  logic [31:0]                  ST_value,
    input  logic                         is_imm,
    input  logic [REG_FILE_ADDR_LEN-1:0] src1,
    input  logic [REG_FILE_ADDR_LEN-1:0] src2,
    input  logic [REG_FILE_ADDR_LEN-1:0] dest,
    input  logic                         MEM_R_EN,
    input  logic                         MEM_W_EN,
    input  logic                         WB_EN,
    input  logic [REG_FILE_ADDR_LEN-1:0] wb_dest,
    input  logic                         wb_en,
    input  logic [31:0]                  wb_value,
    output logic [31:0]                  alu_result_out,
    output logic [31:0]                  st_value_out,
    output logic [REG_FILE_ADDR_LEN-1:0] dest_out,
    output logic                         MEM_R_EN_out,
    output logic                         MEM_W_EN_out,
    output logic                         WB_EN_out,
    output logic                         stall
);

    logic        w_mem_ok;
    logic        w_f1_mem, w_f1_wb;
    logic        w_f2_mem, w_f2_wb;
    logic [31:0] w_op1;
    logic [31:0] w_reg2;
    logic [31:0] w_op2;
    logic [31:0] w_st;
    logic [31:0] w_alu;
    logic [31:0] w_res;
    logic        w_stall;
    logic        w_done;
    logic [31:0] w_md_result;

    // A loaded value is not yet available in the MEM stage, so never forward it.
    assign w_mem_ok = WB_EN_out && !MEM_R_EN_out;

    assign w_f1_mem = (src1 != '0) && w_mem_ok && (dest_out == src1);
    assign w_f1_wb  = (src1 != '0) && wb_en && (wb_dest == src1);
    assign w_f2_mem = (src2 != '0) && w_mem_ok && (dest_out == src2);
    assign w_f2_wb  = (src2 != '0) && wb_en && (wb_dest == src2);

    assign w_op1  = w_f1_mem ? alu_result_out :
                    w_f1_wb  ? wb_value : val1;
    assign w_reg2 = w_f2_mem ? alu_result_out :
                    w_f2_wb  ? wb_value : val2;
    assign w_st   = w_f2_mem ? alu_result_out :
                    w_f2_wb  ? wb_value : ST_value;
    assign w_op2  = is_imm ? val2 : w_reg2;

    // Single-cycle ALU; reserved and muldiv codes produce 0 here.
    always_comb begin
        w_alu = '0;
        case (EXE_CMD)
            EXE_ADD: w_alu = w_op1 + w_op2;
            EXE_SUB: w_alu = w_op1 - w_op2;
            EXE_AND: w_alu = w_op1 & w_op2;
            EXE_OR:  w_alu = w_op1 | w_op2;
            EXE_NOR: w_alu = ~(w_op1 | w_op2);
            EXE_XOR: w_alu = w_op1 ^ w_op2;
            EXE_SLL: w_alu = w_op1 << w_op2[4:0];
            EXE_SRL: w_alu = w_op1 >> w_op2[4:0];
            EXE_SRA: w_alu = $unsigned($signed(w_op1) >>> w_op2[4:0]);
            EXE_SLT: w_alu = {31'd0, $signed(w_op1) < $signed(w_op2)};
            default: w_alu = '0;
        endcase
    end

`ifdef EXE_MULDIV_EN
    md_state_e r_state;
    md_state_e w_next;
    logic      w_start;
    logic      w_busy;
    logic      w_last;

    assign w_busy  = (r_state == MD_BUSY);
    assign w_start = (r_state == MD_IDLE) && is_muldiv(EXE_CMD);
    assign w_stall = w_start || w_busy;
    assign w_done  = (r_state == MD_DONE);

    // Muldiv state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Muldiv next state: 32 BUSY iterations, then one DONE cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            MD_IDLE: if (is_muldiv(EXE_CMD)) w_next = MD_BUSY;
            MD_BUSY: if (w_last) w_next = MD_DONE;
            MD_DONE: w_next = MD_IDLE;
            default: w_next = MD_IDLE;
        endcase
    end

    muldiv_iter u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_step   (w_busy),
        .i_op     (EXE_CMD),
        .i_a      (w_op1),
        .i_b      (w_op2),
        .o_result (w_md_result),
        .o_last   (w_last)
    );
`else
    assign w_stall     = 1'b0;
    assign w_done      = 1'b0;
    assign w_md_result = '0;
`endif

    assign stall = w_stall;
    assign w_res = w_done ? w_md_result : w_alu;

    // EXE/MEM register; inserts a bubble while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_result_out <= '0;
            st_value_out   <= '0;
            dest_out       <= '0;
            MEM_R_EN_out   <= 1'b0;
            MEM_W_EN_out   <= 1'b0;
            WB_EN_out      <= 1'b0;
        end else if (w_stall) begin
            alu_result_out <= w_res;
            st_value_out   <= w_st;
            dest_out       <= '0;
            MEM_R_EN_out   <= 1'b0;
            MEM_W_EN_out   <= 1'b0;
            WB_EN_out      <= 1'b0;
        end else begin
            alu_result_out <= w_res;
            st_value_out   <= w_st;
            dest_out       <= dest;
            MEM_R_EN_out   <= MEM_R_EN;
            MEM_W_EN_out   <= MEM_W_EN;
            WB_EN_out      <= WB_EN;
        end
    end

endmodule
